// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a core's load/store unit and data_mem_ctrl.
// The master issues one request per cycle; the slave answers loads with a
// registered result and flags rejected accesses with err.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic              rd_valid;
  logic              err;

  modport master (
    output req_valid, we, funct3, addr, wd,
    input  req_ready, rd, rd_valid, err
  );

  modport slave (
    input  req_valid, we, funct3, addr, wd,
    output req_ready, rd, rd_valid, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with RV32I byte/half/word access.
// After reset the array is zero-filled one word per cycle (INIT); requests
// are then accepted every cycle (RUN). Loads return one cycle after
// acceptance; misaligned or undefined accesses are rejected with err.
module data_mem_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_ctrl_if.slave bus,
  output logic           init_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt;
  logic [31:0]     mem [DEPTH];

  logic            fire;
  logic            bad;
  logic            code_ok;
  logic            misal;
  logic            st_fire;
  logic            ld_fire;
  logic [AW-1:0]   idx;
  logic [1:0]      boff;
  logic [31:0]     word;
  logic [31:0]     shifted;
  logic [15:0]     half_sel;
  logic [31:0]     ldata;
  logic [31:0]     sdata;
  logic [3:0]      be;

  // Address bits above the wrapped word index carry no meaning here.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[ADDR_W-1:AW+2];

  assign idx  = bus.addr[AW+1:2];
  assign boff = bus.addr[1:0];

  // State register and sweep counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) cnt <= cnt + 1'b1;
    end
  end

  // Next state: leave INIT once the last word has been cleared.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    if (state == S_INIT && cnt == AW'(DEPTH - 1)) state_nx = S_RUN;
  end

  // FSM outputs: busy while sweeping, ready only in RUN.
  always_comb begin
    init_busy     = (state == S_INIT);
    bus.req_ready = (state == S_RUN);
  end

  // Request decode: legal funct3 codes and natural alignment.
  always_comb begin
    fire    = bus.req_valid && bus.req_ready;
    code_ok = bus.we ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                     : (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal   = ((bus.funct3[1:0] == 2'b01) && boff[0]) ||
              ((bus.funct3[1:0] == 2'b10) && (boff != 2'b00));
    bad     = !code_ok || misal;
    st_fire = fire && bus.we && !bad;
    ld_fire = fire && !bus.we;
  end

  // Load path: pick the lane and extend it to 32 bits.
  always_comb begin
    word     = mem[idx];
    shifted  = word >> {boff, 3'b000};
    half_sel = boff[1] ? word[31:16] : word[15:0];
    case (bus.funct3)
      3'b000:  ldata = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ldata = {24'h0, shifted[7:0]};
      3'b001:  ldata = {{16{half_sel[15]}}, half_sel};
      3'b101:  ldata = {16'h0, half_sel};
      default: ldata = word;
    endcase
  end

  // Store path: replicate the right-aligned data and enable the target lanes.
  always_comb begin
    case (bus.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << boff;
        sdata = {4{bus.wd[7:0]}};
      end
      2'b01: begin
        be    = boff[1] ? 4'b1100 : 4'b0011;
        sdata = {2{bus.wd[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        sdata = bus.wd;
      end
    endcase
  end

  // Memory array: zero-fill during INIT, byte-lane writes during RUN.
  // NOTE: the array has no reset; the INIT sweep clears it instead, which
  // keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (st_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= sdata[8*b +: 8];
      end
    end
  end

  // Response registers: rd holds until the next load completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd       <= '0;
      bus.rd_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.rd_valid <= ld_fire;
      bus.err      <= fire && bad;
      if (ld_fire) bus.rd <= bad ? 32'h0 : ldata;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DEPTH=64): zero-fill sweep length,
// sub-word loads/stores, rejection rules, address aliasing and reset abort.
module tb_data_mem_ctrl;

  logic clk;
  logic reset;
  logic init_busy;

  int total;
  int bad;
  int n;
  logic pulse_seen;
  logic ready_seen;

  data_mem_ctrl_if #(.ADDR_W(32)) bus ();

  data_mem_ctrl #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request presented for a single edge; outputs sampled 1 ns later.
  task automatic req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    bus.we        = w;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wd        = d;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] exp);
    req(1'b0, f3, a, 32'h0);
    check({tag, "/rd_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "/err"},      32'(bus.err),      32'd0);
    check({tag, "/rd"},       bus.rd,            exp);
  endtask

  task automatic ld_err(input string tag, input logic [2:0] f3, input logic [31:0] a);
    req(1'b0, f3, a, 32'h0);
    check({tag, "/rd_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "/err"},      32'(bus.err),      32'd1);
    check({tag, "/rd"},       bus.rd,            32'h0);
  endtask

  task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d, input logic exp_err);
    req(1'b1, f3, a, d);
    check({tag, "/rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "/err"},      32'(bus.err),      32'(exp_err));
  endtask

  // Counts edges from reset release until init_busy drops (bounded).
  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.rd_valid || bus.err) pulse_seen = 1'b1;
      if (init_busy && bus.req_ready) ready_seen = 1'b1;
    end while (init_busy && edges < 200);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    pulse_seen    = 1'b0;
    ready_seen    = 1'b0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.we        = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wd        = 32'h0;

    // Reset state, with a request present that must be ignored.
    repeat (3) @(posedge clk);
    bus.req_valid = 1'b1;
    bus.we        = 1'b1;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h0;
    bus.wd        = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("rst/rd",        bus.rd,               32'h0);
    check("rst/rd_valid",  32'(bus.rd_valid),    32'd0);
    check("rst/err",       32'(bus.err),         32'd0);
    check("rst/req_ready", 32'(bus.req_ready),   32'd0);
    check("rst/init_busy", 32'(init_busy),       32'd1);

    // Sweep: request kept asserted throughout, must not be taken.
    @(negedge clk);
    reset = 1'b1;
    wait_ready(n);
    bus.req_valid = 1'b0;
    check("sweep/len",        32'(n),          32'd64);
    check("sweep/no_pulse",   32'(pulse_seen), 32'd0);
    check("sweep/no_ready",   32'(ready_seen), 32'd0);
    check("sweep/req_ready",  32'(bus.req_ready), 32'd1);
    ld("init/lw0",   3'b010, 32'h0000_0000, 32'h0000_0000);
    ld("init/lw3c",  3'b010, 32'h0000_00FC, 32'h0000_0000);

    // Sign/zero extension of byte and half lanes.
    st("ext/sw",  3'b010, 32'h10, 32'h8000_80FF, 1'b0);
    ld("ext/lb",  3'b000, 32'h10, 32'hFFFF_FFFF);
    ld("ext/lbu", 3'b100, 32'h10, 32'h0000_00FF);
    ld("ext/lh",  3'b001, 32'h12, 32'hFFFF_8000);
    ld("ext/lhu", 3'b101, 32'h12, 32'h0000_8000);
    // rd holds, pulses drop after one cycle.
    @(posedge clk);
    #1;
    check("hold/rd_valid", 32'(bus.rd_valid), 32'd0);
    check("hold/err",      32'(bus.err),      32'd0);
    check("hold/rd",       bus.rd,            32'h0000_8000);

    // Byte and half stores touch only their lanes; upper wd bits ignored.
    st("sb/sw", 3'b010, 32'h20, 32'h1122_3344, 1'b0);
    st("sb/sb", 3'b000, 32'h21, 32'h1234_56AB, 1'b0);
    check("sb/rd_kept", bus.rd, 32'h0000_8000);
    ld("sb/lw", 3'b010, 32'h20, 32'h1122_AB44);
    st("sh/hi", 3'b001, 32'h22, 32'h9999_BEEF, 1'b0);
    ld("sh/lw1", 3'b010, 32'h20, 32'hBEEF_AB44);
    st("sh/lo", 3'b001, 32'h20, 32'h0000_5566, 1'b0);
    ld("sh/lw2", 3'b010, 32'h20, 32'hBEEF_5566);
    ld("sb/lb3", 3'b000, 32'h23, 32'hFFFF_FFBE);
    ld("sb/lbu1", 3'b100, 32'h21, 32'h0000_0055);

    // Rejected accesses: memory unchanged, err pulse, loads return rd=0.
    st("rej/sw_ok",  3'b010, 32'h00, 32'hCAFE_F00D, 1'b0);
    st("rej/sw02",   3'b010, 32'h02, 32'h1111_1111, 1'b1);
    ld_err("rej/lh03",  3'b001, 32'h03);
    ld_err("rej/f011",  3'b011, 32'h00);
    ld_err("rej/lw01",  3'b010, 32'h01);
    ld_err("rej/lhu01", 3'b101, 32'h01);
    st("rej/st100",  3'b100, 32'h00, 32'h2222_2222, 1'b1);
    st("rej/sh01",   3'b001, 32'h01, 32'h3333_3333, 1'b1);
    ld("rej/lw00",   3'b010, 32'h00, 32'hCAFE_F00D);
    ld("rej/lb03",   3'b000, 32'h03, 32'hFFFF_FFCA);

    // Aliasing plus back-to-back store/load to the same word.
    st("alias/sw104", 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0);
    ld("alias/lw004", 3'b010, 32'h0000_0004, 32'hDEAD_BEEF);

    // Reset during a completing load: outputs clear at once.
    req(1'b0, 3'b010, 32'h4, 32'h0);
    check("rst_ld/pre_rd", bus.rd, 32'hDEAD_BEEF);
    reset = 1'b0;
    #1;
    check("rst_ld/rd",        bus.rd,             32'h0);
    check("rst_ld/rd_valid",  32'(bus.rd_valid),  32'd0);
    check("rst_ld/init_busy", 32'(init_busy),     32'd1);
    check("rst_ld/req_ready", 32'(bus.req_ready), 32'd0);

    // Reset during cycle 30 of the sweep, then a full restart.
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rst_sw/busy_before", 32'(init_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_sw/busy", 32'(init_busy), 32'd1);
    @(negedge clk);
    reset      = 1'b1;
    pulse_seen = 1'b0;
    ready_seen = 1'b0;
    wait_ready(n);
    check("rst_sw/len",      32'(n),          32'd64);
    check("rst_sw/no_pulse", 32'(pulse_seen), 32'd0);
    check("rst_sw/no_ready", 32'(ready_seen), 32'd0);
    ld("rst_sw/lw4",  3'b010, 32'h4,  32'h0000_0000);
    ld("rst_sw/lw20", 3'b010, 32'h20, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words; power of two, >= 4.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  meaning a request is present.
REQ-006 SHALL have port req_ready  output  1  meaning the block accepts a request this cycle.
REQ-007 SHALL have port we  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port funct3  input  3  meaning RV32I load/store size and sign code.
REQ-009 SHALL have port addr  input  ADDR_W  meaning byte address.
REQ-010 SHALL have port wd  input  32  meaning store data, right-aligned.
REQ-011 SHALL have port rd  output  32  meaning load result, registered.
REQ-012 SHALL have port rd_valid  output  1  meaning one-cycle pulse marking a completed load.
REQ-013 SHALL have port err  output  1  meaning one-cycle pulse marking a rejected access.
REQ-014 SHALL have port init_busy  output  1  meaning the zero-fill sweep is in progress.

Function
REQ-015 SHALL implement two states: INIT and RUN; reset forces INIT.
REQ-016 In INIT, SHALL write zero to word index cnt and increment cnt each cycle; after writing index DEPTH-1, SHALL enter RUN with cnt=0.
REQ-017 SHALL drive init_busy=1 and req_ready=0 in INIT, and init_busy=0 and req_ready=1 in RUN.
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready, one request per cycle, with no back-pressure in RUN.
REQ-019 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-020 Stores SHALL be SB (000, lane addr[1:0]), SH (001, lane addr[1]), and SW (010); only the enabled byte lanes change.
REQ-021 Loads SHALL be LB (000), LH (001), LW (010), LBU (100), and LHU (101); the selected lane is right-aligned, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-022 An accepted load SHALL set rd and pulse rd_valid exactly one cycle after acceptance; rd holds its value until the next load completes.
REQ-023 Misalignment SHALL be defined as addr[0]=1 for SH/LH/LHU, or addr[1:0]!=0 for SW/LW.
REQ-024 A request with an undefined funct3 SHALL be treated the same as a misaligned access, with store funct3 limited to 000/001/010.
REQ-025 A misaligned or undefined access SHALL leave memory unchanged and pulse err one cycle after acceptance.
REQ-026 For a rejected load, SHALL also pulse rd_valid with rd=0 in the same cycle as err.
REQ-027 A load accepted the cycle after a store to the same word SHALL return the stored data, with no stale read.
REQ-028 Requests presented while req_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-029 err and rd_valid SHALL never be asserted for stores, except err as defined in REQ-025.

Reset
REQ-030 While reset=0, SHALL hold rd=0, rd_valid=0, err=0, req_ready=0, init_busy=1, cnt=0, and state INIT.
REQ-031 Reset asserted mid-sweep or mid-access SHALL abort it asynchronously, drop any pending rd_valid/err, and restart the sweep from index 0 on release.
REQ-032 With DEPTH=64, the first request SHALL be accepted no earlier than the 65th rising edge after reset release.

Verification
REQ-033 Scenario (DEPTH=64) -- Release reset and count edges: init_busy stays 1 for 64 edges, then req_ready=1; an LW of any address then returns rd=0x00000000.
REQ-034 Scenario -- SW 0x8000_80FF @0x10, then LB @0x10, LBU @0x10, LH @0x12, LHU @0x12: rd = 0xFFFFFFFF, 0x000000FF, 0xFFFF8000, 0x00008000, each with one rd_valid pulse.
REQ-035 Scenario -- SB 0xAB @0x21 over word 0x11223344 @0x20, then LW @0x20: rd = 0x1122AB44.
REQ-036 Scenario -- SW @0x02, then LH @0x03, then funct3=011 load @0x00: each gets one err pulse; memory is unchanged; the loads give rd_valid=1 with rd=0.
REQ-037 Scenario -- SW 0xDEADBEEF @0x104 (DEPTH=64, aliases word 1), then LW @0x004 on the next cycle: rd=0xDEADBEEF.
REQ-038 Scenario -- Assert reset during cycle 30 of the sweep and during a pending load: outputs clear immediately, no rd_valid pulse follows, and the sweep restarts for the full 64 cycles.
